// File: rtl/ft2_write.sv
// -----------------------------------------------------------------------------
// ft2_write -- transmit side of the FT2232H asynchronous FT245-style FIFO port.
//
// Accepts 32-bit words from fabric on a valid/ready handshake and writes each
// one to the USB chip as four bytes, most significant byte first. Every byte
// write is paced by the chip's TXE# flag (synchronised locally) and by the
// asynchronous write timing set through SETUP/PULSE/RECOVER_CYCLES.
//
// Optional feature macro: FT2_WRITE_FIFO_EN
//   defined   -> words are buffered in a 4-entry FIFO
//   undefined -> words are buffered in a single holding register
//
// Ports
//   clk       in   system clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   d_in      in   [31:0] word to transmit
//   d_valid   in   d_in valid this cycle
//   d_ready   out  buffer can take d_in this cycle
//   txe_n_in  in   FT2232H TXE# (asynchronous, low = chip can take a byte)
//   d_out     out  [7:0] byte for the FT2232H data bus
//   d_oe      out  drive d_out onto the bus when high
//   wr_n_out  out  FT2232H WR#, chip latches the byte on its rising edge
//   rd_n_out  out  FT2232H RD#, held high (this block never reads)
//   busy      out  a word is buffered or being sent
// -----------------------------------------------------------------------------
module ft2_write #(
  parameter int SETUP_CYCLES   = 1,
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_in,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic        txe_n_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        wr_n_out,
  output logic        rd_n_out,
  output logic        busy
);

  localparam int MAX_SP  = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_CYC = (MAX_SP > RECOVER_CYCLES) ? MAX_SP : RECOVER_CYCLES;
  localparam int TMR_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_RECOVER
  } state_t;

  state_t            state;
  logic [31:0]       sr;
  logic [1:0]        cnt;
  logic [TMR_W-1:0]  tmr;
  logic              txe_meta;
  logic              txe_s;
  logic              push;
  logic              pop;
  logic              buf_nempty;
  logic [31:0]       buf_q;

  assign rd_n_out = 1'b1;

  // TXE# synchroniser; resets to "chip full" so nothing is written early.
  // NOTE: registers are always updated with <=, so every flop samples the
  // pre-edge value of its neighbour regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txe_meta <= 1'b1;
      txe_s    <= 1'b1;
    end else begin
      txe_meta <= txe_n_in;
      txe_s    <= txe_meta;
    end
  end

  assign push = d_valid & d_ready;
  assign pop  = (state == S_IDLE) & buf_nempty;

`ifdef FT2_WRITE_FIFO_EN
  logic [31:0] mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  // NOTE: the storage array has no reset; the pointers and count reset, so
  // stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: ;
      endcase
    end
  end

  // Ready comes from the registered count only: a pop while full does not
  // reopen the input in the same cycle.
  assign d_ready    = (count != 3'd4);
  assign buf_nempty = (count != 3'd0);
  assign buf_q      = mem[rd_ptr];
`else
  logic        hold_valid;
  logic [31:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_q     <= '0;
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_q     <= d_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign d_ready    = ~hold_valid;
  assign buf_nempty = hold_valid;
  assign buf_q      = hold_q;
`endif

  assign busy = (state != S_IDLE) | buf_nempty;

  // Byte sequencer. Bus outputs are registered and change together with the
  // state, so d_out only ever moves on entry to SETUP, well clear of WR# rising.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sr       <= '0;
      cnt      <= '0;
      tmr      <= '0;
      d_out    <= '0;
      d_oe     <= 1'b0;
      wr_n_out <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (buf_nempty) begin
            sr    <= buf_q;
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!txe_s) begin
            d_oe  <= 1'b1;
            d_out <= sr[31:24];
            tmr   <= TMR_W'(SETUP_CYCLES - 1);
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tmr == '0) begin
            wr_n_out <= 1'b0;
            tmr      <= TMR_W'(PULSE_CYCLES - 1);
            state    <= S_STROBE;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_STROBE: begin
          // TXE# is not looked at here: a started byte always completes.
          if (tmr == '0) begin
            wr_n_out <= 1'b1;
            tmr      <= TMR_W'(RECOVER_CYCLES - 1);
            state    <= S_RECOVER;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        S_RECOVER: begin
          // Bus is held for one cycle after WR# rises (chip hold time), then
          // released while the next byte moves to the top of sr.
          if (tmr == TMR_W'(RECOVER_CYCLES - 1)) begin
            d_oe <= 1'b0;
            sr   <= {sr[23:0], 8'h00};
          end
          if (tmr == '0) begin
            if (cnt == 2'd3) begin
              state <= S_IDLE;
            end else begin
              cnt   <= cnt + 2'd1;
              state <= S_WAIT;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft2_write.sv
`timescale 1ns/1ps
module tb_ft2_write;

  logic        clk;
  logic        rst;
  logic [31:0] d_in;
  logic        d_valid;
  logic        d_ready;
  logic        txe_n_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic        wr_n_out;
  logic        rd_n_out;
  logic        busy;

  ft2_write #(
    .SETUP_CYCLES  (1),
    .PULSE_CYCLES  (2),
    .RECOVER_CYCLES(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d_in    (d_in),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .txe_n_in(txe_n_in),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .wr_n_out(wr_n_out),
    .rd_n_out(rd_n_out),
    .busy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: logs each completed WR# pulse (byte, cycle of rising edge,
  // low length) and counts protocol violations.
  logic [7:0] byte_q [$];
  int         rise_q [$];
  int         len_q  [$];
  int         oe_viol   = 0;
  int         dout_viol = 0;
  int         rd_viol   = 0;

  initial begin : mon
    logic       pw;
    logic [7:0] pd;
    logic [7:0] lb;
    int         ll;
    pw = 1'b1; pd = 8'h00; lb = 8'h00; ll = 0;
    forever begin
      @(negedge clk);
      if (rd_n_out !== 1'b1) rd_viol++;
      if (rst) begin
        pw = 1'b1; pd = d_out; ll = 0;
      end else begin
        if (wr_n_out === 1'b0) begin
          ll++;
          lb = d_out;
          if (d_oe !== 1'b1) oe_viol++;
        end
        if (wr_n_out === 1'b1 && pw === 1'b0) begin
          byte_q.push_back(lb);
          rise_q.push_back(cyc);
          len_q.push_back(ll);
          ll = 0;
        end
        if (d_out !== pd && (wr_n_out !== 1'b1 || pw !== 1'b1)) dout_viol++;
        pw = wr_n_out;
        pd = d_out;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    byte_q.delete();
    rise_q.delete();
    len_q.delete();
  endtask

  // Presents one word and holds it until accepted; pc = cycle of the
  // accepting clock edge.
  task automatic push_word(input logic [31:0] w, output int pc);
    int t;
    t = 0;
    d_in    = w;
    d_valid = 1'b1;
    while (d_ready !== 1'b1 && t < 50) begin
      tick(1);
      t++;
    end
    if (t == 50) check("push_timeout", t, 0);
    tick(1);
    pc      = cyc;
    d_valid = 1'b0;
  endtask

  task automatic wait_pulses(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rise_q.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check(tag, rise_q.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin
      tick(1);
      t++;
    end
    check(tag, busy, 0);
  endtask

  logic [31:0] word;
  logic [31:0] bp_words [6];
  logic        bp_rdy   [6];
  int          bp_acc   [$];
  int          pc;
  int          f;
  int          t;
  int          bad;

  initial begin
    rst = 1'b1; d_valid = 1'b0; d_in = '0; txe_n_in = 1'b1;

    // ---- reset state ----
    tick(3);
    check("rst_wr_n",  wr_n_out, 1);
    check("rst_rd_n",  rd_n_out, 1);
    check("rst_oe",    d_oe,     0);
    check("rst_dout",  d_out,    8'h00);
    check("rst_busy",  busy,     0);
    check("rst_ready", d_ready,  1);
    rst = 1'b0;

    // ---- single word, TXE# low ----
    txe_n_in = 1'b0;
    tick(4);
    clear_log();
    word = 32'hA1B2C3D4;
    push_word(word, pc);
    wait_pulses("single_cnt", 4, 80);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("single_byte%0d", i), byte_q[i], word[31-8*i -: 8]);
      check($sformatf("single_len%0d", i), len_q[i], 2);
    end
    check("single_first", rise_q[0] - pc, 5);
    for (int i = 1; i < 4; i++)
      check($sformatf("single_gap%0d", i), rise_q[i] - rise_q[i-1], 6);
    while (cyc < rise_q[3] + 1) tick(1);
    check("single_busy_recover", busy, 1);
    tick(1);
    check("single_busy_done", busy, 0);

    // ---- TXE# throttle during byte 2 strobe ----
    clear_log();
    push_word(32'h11223344, pc);
    t = 0;
    while (!(rise_q.size() == 1 && wr_n_out === 1'b0) && t < 100) begin
      tick(1);
      t++;
    end
    check("thr_reach_b2", t < 100, 1);
    txe_n_in = 1'b1;
    tick(20);
    check("thr_held_cnt", rise_q.size(), 2);
    check("thr_b0", byte_q[0], 8'h11);
    check("thr_b1", byte_q[1], 8'h22);
    check("thr_busy", busy, 1);
    f = cyc;
    txe_n_in = 1'b0;
    tick(2);
    check("thr_oe_f2", d_oe, 0);
    tick(1);
    check("thr_oe_f3", d_oe, 1);
    wait_pulses("thr_cnt", 4, 60);
    check("thr_b2", byte_q[2], 8'h33);
    check("thr_b3", byte_q[3], 8'h44);
    check("thr_lat", rise_q[2] - f, 6);
    check("thr_gap", rise_q[3] - rise_q[2], 6);
    wait_idle("thr_idle");

    // ---- backpressure: 6 back-to-back words with TXE# high ----
    for (int i = 0; i < 6; i++)
      bp_words[i] = {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)};
`ifdef FT2_WRITE_FIFO_EN
    bp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_acc = '{0, 1, 2, 3, 4};
`else
    bp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    bp_acc = '{0, 2};
`endif
    txe_n_in = 1'b1;
    tick(3);
    clear_log();
    for (int i = 0; i < 6; i++) begin
      d_in    = bp_words[i];
      d_valid = 1'b1;
      check($sformatf("bp_ready%0d", i), d_ready, bp_rdy[i]);
      tick(1);
    end
    d_valid = 1'b0;
    tick(5);
    check("bp_no_wr_txe_high", rise_q.size(), 0);
    txe_n_in = 1'b0;
    wait_pulses("bp_cnt", 4 * bp_acc.size(), 400);
    for (int k = 0; k < bp_acc.size(); k++) begin
      word = bp_words[bp_acc[k]];
      check($sformatf("bp_word%0d", k),
            {byte_q[4*k], byte_q[4*k+1], byte_q[4*k+2], byte_q[4*k+3]}, word);
    end
    tick(20);
    check("bp_no_dup", rise_q.size(), 4 * bp_acc.size());
    check("bp_idle", busy, 0);

    // ---- reset during byte 3 strobe, with a second word buffered ----
    clear_log();
    push_word(32'hCAFEF00D, pc);
    push_word(32'h5EED1234, pc);
    t = 0;
    while (!(rise_q.size() == 2 && wr_n_out === 1'b0) && t < 100) begin
      tick(1);
      t++;
    end
    check("rstop_reach_b3", t < 100, 1);
    check("rstop_b0", byte_q[0], 8'hCA);
    check("rstop_b1", byte_q[1], 8'hFE);
    rst = 1'b1;
    #1;
    check("rstop_wr_n",  wr_n_out, 1);
    check("rstop_oe",    d_oe,     0);
    check("rstop_ready", d_ready,  1);
    check("rstop_busy",  busy,     0);
    tick(2);
    rst = 1'b0;
    tick(30);
    check("rstop_no_wr", rise_q.size(), 2);
    check("rstop_busy_after", busy, 0);

    // ---- idle bus for 100 cycles, TXE# low ----
    clear_log();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (wr_n_out !== 1'b1 || d_oe !== 1'b0 || rd_n_out !== 1'b1) bad++;
    end
    check("idle_bus", bad, 0);
    check("idle_no_wr", rise_q.size(), 0);

    // ---- fresh word after reset still goes out intact ----
    word = 32'h0F1E2D3C;
    push_word(word, pc);
    wait_pulses("post_cnt", 4, 80);
    check("post_word", {byte_q[0], byte_q[1], byte_q[2], byte_q[3]}, word);
    wait_idle("post_idle");

    // ---- protocol invariants over the whole run ----
    check("inv_oe_during_wr", oe_viol,   0);
    check("inv_dout_stable",  dout_viol, 0);
    check("inv_rd_high",      rd_viol,   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
